// File: rtl/tdm_demux4.sv
// tdm_demux4: 1:4 time-division demultiplexer.
//
// Takes a serialized stream of lane samples (order I0, I1, I2, I3). A rotating
// 2-bit channel counter steers each accepted sample into its lane register.
// When lane 3 is written, all four lanes are published together in `frame`.
//
// Optional feature: define TDM_DEMUX4_EXT_SEL_EN to add the `sel` port.
// The lane then comes from `sel` instead of the counter.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset; wins over all other inputs
//   en         in   block enable; low freezes all state
//   din        in   W-bit serialized sample
//   din_valid  in   din carries a sample this cycle
//   sync       in   start-of-frame marker; forces the sample to lane 0
//   sel        in   2-bit external lane select (TDM_DEMUX4_EXT_SEL_EN only)
//   y0..y3     out  lane holding registers
//   y_strobe   out  one-cycle per-lane write strobe, bit k = lane k
//   frame      out  {y0,y1,y2,y3} snapshot taken on frame completion
//   frame_done out  one-cycle pulse when frame updates
//   chan       out  lane the next sample goes to
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sync,
`ifdef TDM_DEMUX4_EXT_SEL_EN
  input  logic [1:0]     sel,
`endif
  output logic [W-1:0]   y0,
  output logic [W-1:0]   y1,
  output logic [W-1:0]   y2,
  output logic [W-1:0]   y3,
  output logic [3:0]     y_strobe,
  output logic [4*W-1:0] frame,
  output logic           frame_done,
  output logic [1:0]     chan
);

  logic [W-1:0]   lane_q [4];
  logic [3:0]     strobe_q;
  logic [4*W-1:0] frame_q;
  logic           frame_done_q;
  logic [1:0]     chan_q;

  logic           acc;
  logic [1:0]     lane;

  always_comb begin
    acc = en & din_valid;
`ifdef TDM_DEMUX4_EXT_SEL_EN
    lane = sync ? 2'd0 : sel;
`else
    lane = sync ? 2'd0 : chan_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      strobe_q     <= 4'b0000;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      chan_q       <= 2'd0;
    end else begin
      // Strobes are pulses: they drop in any cycle without an accept, even with en low.
      strobe_q     <= acc ? (4'b0001 << lane) : 4'b0000;
      frame_done_q <= acc && (lane == 2'd3);
      if (acc) begin
        lane_q[lane] <= din;
        chan_q       <= lane + 2'd1;
        if (lane == 2'd3) begin
          // Take din directly: lane_q[3] only holds it from the next cycle.
          frame_q <= {lane_q[0], lane_q[1], lane_q[2], din};
        end
      end
    end
  end

  assign y0         = lane_q[0];
  assign y1         = lane_q[1];
  assign y2         = lane_q[2];
  assign y3         = lane_q[3];
  assign y_strobe   = strobe_q;
  assign frame      = frame_q;
  assign frame_done = frame_done_q;
  assign chan       = chan_q;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Sequential 1:4 time-division demultiplexer, the receive-side counterpart of the 4:1 decoder-based mux. Takes a serialized stream of lane samples (lane order I0, I1, I2, I3), steers each sample to its lane register with a rotating 2-bit channel counter, and publishes a complete 4-lane frame atomically once lane 3 is written. It sits after the mux/serial link and feeds parallel consumers that need per-lane strobes or a coherent frame.

## Interface
- `W`, default 1: sample width in bits per lane.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable; low freezes all state.
- `din`  in  W  incoming serialized sample.
- `din_valid`  in  1  `din` carries a sample this cycle.
- `sync`  in  1  start-of-frame marker; the qualifying sample is forced to lane 0.
- `sel`  in  2  external lane select; present only with `TDM_DEMUX4_EXT_SEL_EN`.
- `y0`, `y1`, `y2`, `y3`  out  W each  lane holding registers.
- `y_strobe`  out  4  one-cycle per-lane write strobe; bit k = lane k.
- `frame`  out  4W  snapshot `{y0,y1,y2,y3}` (y0 in MSBs), updated only on frame completion.
- `frame_done`  out  1  one-cycle pulse when `frame` updates.
- `chan`  out  2  current channel counter, the lane the next sample goes to.

## Operation
- Accept condition: `acc = en & din_valid`. With `acc` low, nothing changes and strobes and `frame_done` are 0.
- Lane selection:
  - `lane = sync ? 0 : chan` (counter mode).
  - With `acc`: `y[lane] <= din`, `y_strobe <= onehot(lane)`, `chan <= lane + 1` mod 4.
  - The counter wraps 3 → 0.
- Frame completion:
  - With `acc` and `lane == 3`: `frame <= {y0,y1,y2,din}` (the new lane-3 value is included) and `frame_done <= 1`.
- `sync` with `chan` already 0 is harmless.
- `sync` mid-frame discards the partial frame:
  - No `frame_done` is produced.
  - Lanes already written keep their values until overwritten.
- `en` low mid-frame suspends; the frame resumes at the held `chan` when `en` returns.
- Samples with `din_valid` low never advance `chan`.

## Timing
- All outputs are registered. Latency from accepted sample to `y*`, `y_strobe`, `frame` and `frame_done` is 1 cycle.
- `y_strobe` and `frame_done` are single-cycle pulses. They return to 0 in any cycle without a corresponding accept.
- Back-to-back accepts are sustained at 1 sample/cycle: full frame every 4 cycles, so `frame_done` can be at most one per 4 accepts.
- Reset values: `y0..y3 = 0`, `frame = 0`, `y_strobe = 4'b0000`, `frame_done = 0`, `chan = 2'b00`.
- `rst` has priority over `en`, `din_valid` and `sync` in the same cycle: the sample is dropped.
- Reset mid-frame discards the partial frame with no `frame_done`.

## Configuration
- `TDM_DEMUX4_EXT_SEL_EN` defined:
  - The `sel` port exists and `lane = sync ? 0 : sel`.
  - `chan` still updates to `lane + 1` for observability.
  - `frame_done` fires on every accepted lane-3 write.
  - Out-of-order lanes are allowed; `frame` takes the current `y0..y2` contents.
- Not defined: no `sel` port; lane comes from the internal counter only (behaviour above).

## Test plan
- **Reset:** assert `rst` 2 cycles with `din_valid=1`, `din=1`.
  - Expect all outputs 0 and `chan=0`.
  - Expect no strobe during or 1 cycle after reset.
- **Sweep all patterns:** W=1, `en=1`, 16 frames streaming bits of k = 0..15 (I0 first), `din_valid` high continuously.
  - Expect `frame = k` and `frame_done` pulse every 4th cycle.
  - Expect `y_strobe` sequence 0001, 0010, 0100, 1000 repeating.
- **Gaps:** frame 4'b1011 with `din_valid` low on cycles 2 and 5.
  - Expect `chan` held across the gaps.
  - Expect `frame = 4'b1011` after the 4th accept and exactly one `frame_done`.
- **Resync:** send lanes 0,1 (values 1,1), then `sync` with `din=0`, then 1,0,1.
  - Expect no `frame_done` after the first two samples.
  - Expect `frame = 4'b0101`.
- **Enable freeze / reset priority:** drop `en` after 2 accepts for 3 cycles, then complete the frame.
  - Expect no strobes while `en` is low and `frame_done` after 2 more accepts.
  - Separately, assert `rst` with `acc` and lane 3: expect no `frame_done` and `chan=0`.
- **Macro on (`TDM_DEMUX4_EXT_SEL_EN`):** `sel` = 2,0,3 with `din` = 1,1,0.
  - Expect `y2=1`, `y0=1`.
  - Expect `frame_done` on the lane-3 write with `frame = 4'b1010`.
